mux_n_to_1_arb_reg: RTL and testbench

- Parametrised successor to the team's 2-to-1 32-bit mux: NUM_CH input channels of DATA_WIDTH bits each, merged onto one registered output.
- Each input and the output use valid/ready handshakes.
- Arbitration mode is selectable at build time: fixed priority, round robin, or static select.
- Sits between multiple producers (e.g. ALU/datapath result sources) and a single downstream consumer.

---
 rtl/mux_n_to_1_arb_reg.sv | 129 ++++++++++++
 tb/tb_mux_n_to_1_arb_reg.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_arb_reg.sv
// N-to-1 valid/ready channel merge onto one registered output.
// Arbitration is fixed priority, round robin or static select.
module mux_n_to_1_arb_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int MODE       = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic                  load_en;
  logic                  xfer;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [NUM_CH-1:0]     g_fp;
  logic [NUM_CH-1:0]     g_rr;
  logic [NUM_CH-1:0]     g_st;
  logic [NUM_CH-1:0]     grant;
  logic [SEL_WIDTH-1:0]  i_fp;
  logic [SEL_WIDTH-1:0]  i_rr;
  logic [SEL_WIDTH-1:0]  i_st;
  logic [SEL_WIDTH-1:0]  gidx;
  logic [DATA_WIDTH-1:0] gdata;

  assign load_en = !out_valid || out_ready;

  // Downward scan: the last hit written is the lowest index.
  always_comb begin
    g_fp = '0;
    i_fp = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        g_fp    = '0;
        g_fp[i] = 1'b1;
        i_fp    = SEL_WIDTH'(i);
      end
    end
  end

  always_comb begin
    int  j;
    logic found;
    g_rr  = '0;
    i_rr  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && in_valid[j]) begin
        found   = 1'b1;
        g_rr[j] = 1'b1;
        i_rr    = SEL_WIDTH'(j);
      end
    end
  end

  always_comb begin
    g_st = '0;
    i_st = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(sel) == i && in_valid[i]) begin
        g_st[i] = 1'b1;
        i_st    = SEL_WIDTH'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    gidx  = '0;
    case (MODE)
      0: begin
        grant = g_fp;
        gidx  = i_fp;
      end
      1: begin
        grant = g_rr;
        gidx  = i_rr;
      end
      2: begin
        grant = g_st;
        gidx  = i_st;
      end
      default: begin
        grant = '0;
        gidx  = '0;
      end
    endcase
  end

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) gdata = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign in_ready = load_en ? grant : '0;
  assign xfer     = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_WIDTH'(NUM_CH - 1);
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_ch    <= gidx;
        rr_ptr    <= gidx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_arb_reg.sv
// Directed bench for mux_n_to_1_arb_reg in all three arbitration modes.
// Three instances share stimulus; each test starts from reset.
module tb_mux_n_to_1_arb_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic         out_ready;
  logic [1:0]   sel2;
  logic [2:0]   sel3;

  logic [3:0]  fp_rdy, rr_rdy, st_rdy;
  logic [31:0] fp_data, rr_data, st_data;
  logic [1:0]  fp_ch, rr_ch;
  logic [2:0]  st_ch;
  logic        fp_vld, rr_vld, st_vld;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] d [4];

  always #5 clk = ~clk;

  mux_n_to_1_arb_reg #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2), .MODE(0))
  u_fp (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fp_rdy), .sel(sel2), .out_data(fp_data), .out_ch(fp_ch),
        .out_valid(fp_vld), .out_ready(out_ready));

  mux_n_to_1_arb_reg #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2), .MODE(1))
  u_rr (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_rdy), .sel(sel2), .out_data(rr_data), .out_ch(rr_ch),
        .out_valid(rr_vld), .out_ready(out_ready));

  mux_n_to_1_arb_reg #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(3), .MODE(2))
  u_st (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(st_rdy), .sel(sel3), .out_data(st_data), .out_ch(st_ch),
        .out_valid(st_vld), .out_ready(out_ready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    sel2      = '0;
    sel3      = '0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (fp_vld !== 1'b0 || fp_data !== 32'h0 || fp_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_fp: vld=%b data=%h ch=%0d, want 0/0/0", fp_vld, fp_data, fp_ch);
    end
    n_chk++;
    if (rr_vld !== 1'b0 || st_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vld: rr=%b st=%b, want 0/0", rr_vld, st_vld);
    end
    n_chk++;
    if (rr_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle_rdy: got %b want 0000", rr_rdy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_data   = {d[3], d[2], d[1], 32'h5A5A_1234};
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (fp_vld !== 1'b1 || fp_data !== 32'h5A5A_1234) begin
      n_fail++;
      $display("FAIL areset_pre: vld=%b data=%h, want 1/5a5a1234", fp_vld, fp_data);
    end
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (fp_vld !== 1'b0 || fp_data !== 32'h0 || fp_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL areset_async: vld=%b data=%h ch=%0d, want 0/0/0", fp_vld, fp_data, fp_ch);
    end
    in_valid = '0;
    rst_n    = 1'b1;
    tick();
    tick();
    n_chk++;
    if (fp_vld !== 1'b0 || rr_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_idle: fp=%b rr=%b, want 0/0", fp_vld, rr_vld);
    end
  endtask

  task automatic test_priority();
    do_reset();
    in_data   = {32'hAAAA_BBBB, 32'h0, 32'h1111_1111, 32'h0};
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (fp_rdy !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_rdy: got %b want 0010", fp_rdy);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (fp_vld !== 1'b1 || fp_data !== 32'h1111_1111 || fp_ch !== 2'd1) begin
        n_fail++;
        $display("FAIL prio_out[%0d]: vld=%b data=%h ch=%0d, want 1/11111111/1",
                 c, fp_vld, fp_data, fp_ch);
      end
    end
  endtask

  task automatic test_rr_fair();
    do_reset();
    in_data   = {d[3], d[2], d[1], d[0]};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (rr_rdy !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_first_rdy: got %b want 0001", rr_rdy);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_chk++;
      if (rr_vld !== 1'b1 || rr_ch !== 2'(c % 4) || rr_data !== d[c % 4]) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: vld=%b ch=%0d data=%h, want 1/%0d/%h",
                 c, rr_vld, rr_ch, rr_data, c % 4, d[c % 4]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_data   = {d[3], d[2], d[1], d[0]};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (rr_rdy !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_rdy[%0d]: got %b want 0000", c, rr_rdy);
      end
      tick();
      n_chk++;
      if (rr_vld !== 1'b1 || rr_ch !== 2'd0 || rr_data !== d[0]) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b ch=%0d data=%h, want 1/0/%h",
                 c, rr_vld, rr_ch, rr_data, d[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (rr_rdy !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release_rdy: got %b want 0010", rr_rdy);
    end
    tick();
    n_chk++;
    if (rr_vld !== 1'b1 || rr_ch !== 2'd1 || rr_data !== d[1]) begin
      n_fail++;
      $display("FAIL bp_drain: vld=%b ch=%0d data=%h, want 1/1/%h",
               rr_vld, rr_ch, rr_data, d[1]);
    end
  endtask

  task automatic test_static();
    do_reset();
    in_data   = {d[3], 32'hFFFF_0000, d[1], 32'hCAFE_0001};
    in_valid  = 4'b0101;
    sel3      = 3'd2;
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (st_rdy !== 4'b0100) begin
      n_fail++;
      $display("FAIL st_rdy: got %b want 0100", st_rdy);
    end
    tick();
    n_chk++;
    if (st_vld !== 1'b1 || st_ch !== 3'd2 || st_data !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL st_out: vld=%b ch=%0d data=%h, want 1/2/ffff0000",
               st_vld, st_ch, st_data);
    end
    sel3 = 3'd5;
    #1;
    n_chk++;
    if (st_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL st_oob_rdy: got %b want 0000", st_rdy);
    end
    tick();
    n_chk++;
    if (st_vld !== 1'b0 || st_ch !== 3'd2 || st_data !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL st_oob_out: vld=%b ch=%0d data=%h, want 0/2/ffff0000",
               st_vld, st_ch, st_data);
    end
  endtask

  task automatic test_drain();
    do_reset();
    in_data   = {d[3], 32'h1234_5678, d[1], d[0]};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    n_chk++;
    if (fp_vld !== 1'b1 || fp_data !== 32'h1234_5678 || fp_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL drain_word: vld=%b data=%h ch=%0d, want 1/12345678/2",
               fp_vld, fp_data, fp_ch);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_chk++;
      if (fp_vld !== 1'b0 || fp_data !== 32'h1234_5678 || fp_ch !== 2'd2) begin
        n_fail++;
        $display("FAIL drain_empty[%0d]: vld=%b data=%h ch=%0d, want 0/12345678/2",
                 c, fp_vld, fp_data, fp_ch);
      end
    end
  endtask

  initial begin
    d[0] = 32'h0000_0000;
    d[1] = 32'h000F_F000;
    d[2] = 32'hFFFF_0000;
    d[3] = 32'hAAAA_BBBB;
    test_reset();
    test_async_reset();
    test_priority();
    test_rr_fair();
    test_back_to_back();
    test_static();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
